// File: rtl/flipflop_pkg.sv
// Shared types for the flip-flop bank: per-bit update mode encoding.
package flipflop_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_JK = 2'b00,
    MODE_SR = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

endpackage : flipflop_pkg

// File: rtl/ff_next_bit.sv
// Combinational next-state and SR-illegal detection for one bank bit.
module ff_next_bit
  import flipflop_pkg::*;
(
  input  logic       q,
  input  logic       j,
  input  logic       k,
  input  logic [1:0] mode,
  output logic       q_next,
  output logic       ill
);

  always_comb begin
    q_next = q;
    ill    = 1'b0;
    case (mode_e'(mode))
      MODE_JK: begin
        case ({j, k})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
      MODE_SR: begin
        case ({j, k})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   ill    = 1'b1;   // S=R=1: keep state, flag it
          default: q_next = q;
        endcase
      end
      MODE_D:  q_next = j;
      MODE_T:  q_next = j ? ~q : q;
      default: q_next = q;
    endcase
  end

endmodule : ff_next_bit

// File: rtl/flipflop_bank.sv
// WIDTH-bit bank of mode-selectable flip-flops with parallel load,
// per-bit change mask and sticky SR-illegal tracking.
module flipflop_bank
  import flipflop_pkg::*;
#(
  parameter int unsigned           WIDTH   = 8,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             illegal_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] changed,
  output logic [WIDTH-1:0] illegal,
  output logic             illegal_sticky
);

  logic [WIDTH-1:0] upd_q;
  logic [WIDTH-1:0] upd_ill;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] ill_nxt;
  logic             sticky_nxt;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    ff_next_bit u_bit (
      .q      (q[i]),
      .j      (j[i]),
      .k      (k[i]),
      .mode   (mode),
      .q_next (upd_q[i]),
      .ill    (upd_ill[i])
    );
  end

  // Load beats enable; anything else holds with no illegal report.
  always_comb begin
    q_nxt   = q;
    ill_nxt = '0;
    if (load) begin
      q_nxt = load_data;
    end else if (en) begin
      q_nxt   = upd_q;
      ill_nxt = upd_ill;
    end
  end

  // A fresh illegal event wins over a same-edge clear.
  always_comb begin
    sticky_nxt = illegal_sticky;
    if (|ill_nxt) begin
      sticky_nxt = 1'b1;
    end else if (illegal_clr) begin
      sticky_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q              <= RST_VAL;
      changed        <= '0;
      illegal        <= '0;
      illegal_sticky <= 1'b0;
    end else begin
      q              <= q_nxt;
      changed        <= q_nxt ^ q;
      illegal        <= ill_nxt;
      illegal_sticky <= sticky_nxt;
    end
  end

  assign q_bar = ~q;

endmodule : flipflop_bank

// File: tb/tb_flipflop_bank.sv
// Directed self-checking bench for flipflop_bank (WIDTH=8, RST_VAL=8'hA5).
module tb_flipflop_bank;
  import flipflop_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [7:0] j;
  logic [7:0] k;
  logic       load;
  logic [7:0] load_data;
  logic       illegal_clr;
  logic [7:0] q;
  logic [7:0] q_bar;
  logic [7:0] changed;
  logic [7:0] illegal;
  logic       illegal_sticky;

  int n_tests;
  int n_fail;

  flipflop_bank #(
    .WIDTH   (8),
    .RST_VAL (8'hA5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .mode           (mode),
    .j              (j),
    .k              (k),
    .load           (load),
    .load_data      (load_data),
    .illegal_clr    (illegal_clr),
    .q              (q),
    .q_bar          (q_bar),
    .changed        (changed),
    .illegal        (illegal),
    .illegal_sticky (illegal_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    en          = 1'b0;
    mode        = MODE_JK;
    j           = '0;
    k           = '0;
    load        = 1'b0;
    load_data   = '0;
    illegal_clr = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_q", q, 8'hA5);
    chk("rst_qbar", q_bar, 8'h5A);
    chk("rst_changed", changed, 8'h00);
    chk("rst_illegal", illegal, 8'h00);
    chk("rst_sticky", {7'd0, illegal_sticky}, 8'h00);
    rst_n = 1'b1;

    // Disturb state, then reset asynchronously mid-cycle
    load = 1'b1; load_data = 8'h3C;
    tick();
    chk("load_q", q, 8'h3C);
    chk("load_changed", changed, 8'h99);
    load = 1'b0;
    mode = MODE_SR; en = 1'b1; j = 8'h01; k = 8'h01;
    tick();
    chk("pre_rst_illegal", illegal, 8'h01);
    chk("pre_rst_sticky", {7'd0, illegal_sticky}, 8'h01);
    en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", q, 8'hA5);
    chk("async_rst_qbar", q_bar, 8'h5A);
    chk("async_rst_changed", changed, 8'h00);
    chk("async_rst_illegal", illegal, 8'h00);
    chk("async_rst_sticky", {7'd0, illegal_sticky}, 8'h00);
    tick();
    rst_n = 1'b1;

    // JK mode
    load = 1'b1; load_data = 8'h00;
    tick();
    chk("jk_init_q", q, 8'h00);
    load = 1'b0;
    mode = MODE_JK; en = 1'b1; j = 8'hF0; k = 8'h0F;
    tick();
    chk("jk_setclr_q", q, 8'hF0);
    chk("jk_setclr_changed", changed, 8'hF0);
    j = 8'hFF; k = 8'hFF;
    tick();
    chk("jk_toggle_q", q, 8'h0F);
    chk("jk_toggle_qbar", q_bar, 8'hF0);
    chk("jk_toggle_changed", changed, 8'hFF);

    // SR mode with illegal detection and sticky flag
    load = 1'b1; load_data = 8'h0F;
    tick();
    chk("sr_init_q", q, 8'h0F);
    load = 1'b0;
    mode = MODE_SR; en = 1'b1; j = 8'h81; k = 8'h01;
    tick();
    chk("sr_q", q, 8'h8F);
    chk("sr_illegal", illegal, 8'h01);
    chk("sr_changed", changed, 8'h80);
    chk("sr_sticky", {7'd0, illegal_sticky}, 8'h01);
    illegal_clr = 1'b1; j = 8'h00; k = 8'h00;
    tick();
    chk("sr_clr_sticky", {7'd0, illegal_sticky}, 8'h00);
    chk("sr_clr_illegal", illegal, 8'h00);
    chk("sr_clr_q", q, 8'h8F);
    j = 8'h02; k = 8'h02;
    tick();
    chk("sr_clr_vs_set_sticky", {7'd0, illegal_sticky}, 8'h01);
    chk("sr_clr_vs_set_illegal", illegal, 8'h02);
    chk("sr_clr_vs_set_q", q, 8'h8F);
    illegal_clr = 1'b0; en = 1'b0;
    tick();
    chk("sr_hold_sticky", {7'd0, illegal_sticky}, 8'h01);
    chk("sr_hold_illegal", illegal, 8'h00);

    // D mode (k ignored)
    mode = MODE_D; en = 1'b1; j = 8'h3C; k = 8'hFF;
    tick();
    chk("d_q", q, 8'h3C);
    chk("d_changed", changed, 8'hB3);
    chk("d_illegal", illegal, 8'h00);

    // T mode: bit 0 toggles every edge
    mode = MODE_T; j = 8'h01; k = 8'h00;
    tick();
    chk("t1_q", q, 8'h3D);
    chk("t1_changed", changed, 8'h01);
    tick();
    chk("t2_q", q, 8'h3C);
    chk("t2_changed", changed, 8'h01);
    tick();
    chk("t3_q", q, 8'h3D);
    chk("t3_changed", changed, 8'h01);
    tick();
    chk("t4_q", q, 8'h3C);
    chk("t4_changed", changed, 8'h01);

    // Load beats an enabled toggle-all
    load = 1'b1; load_data = 8'h77; mode = MODE_JK; en = 1'b1; j = 8'hFF; k = 8'hFF;
    tick();
    chk("prio_load_q", q, 8'h77);
    chk("prio_load_changed", changed, 8'h4B);
    chk("prio_load_illegal", illegal, 8'h00);

    // Disabled: SR 11 neither updates nor flags; clear drops sticky
    load = 1'b0; en = 1'b0; mode = MODE_SR; j = 8'hFF; k = 8'hFF; illegal_clr = 1'b1;
    tick();
    chk("hold_q", q, 8'h77);
    chk("hold_changed", changed, 8'h00);
    chk("hold_illegal", illegal, 8'h00);
    chk("hold_sticky", {7'd0, illegal_sticky}, 8'h00);
    illegal_clr = 1'b0; j = 8'h5A; k = 8'hA5; mode = MODE_JK;
    tick();
    chk("hold2_q", q, 8'h77);
    chk("hold2_changed", changed, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_flipflop_bank
